// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: result classes, register address width and
// forwarding select encodings used by the scoreboard and the forwarding unit.
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_LOAD = 2'b01;
    localparam logic [1:0] CLS_MUL  = 2'b10;

    // Forwarding mux selects for the EX-stage operand muxes.
    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // Cycles after issue until a result of this class reaches a forwarding path.
    // The reserved class behaves as ALU.
    function automatic int unsigned class_latency(input logic [1:0] cls,
                                                  input int unsigned mul_lat);
        int unsigned lat;
        lat = 0;
        case (cls)
            CLS_LOAD: lat = 1;
            CLS_MUL:  lat = mul_lat - 1;
            default:  lat = 0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One architectural register's scoreboard state: forwarding countdown and
// outstanding-write flag.
module sb_entry #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [CNT_W-1:0] set_cnt,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             pending
);

    // A new issue overrides both the running countdown and a same-cycle writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else if (set) begin
            cnt     <= set_cnt;
            pending <= 1'b1;
        end else begin
            if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
            if (clr)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side scoreboard: stalls the ID instruction until its operands and
// destination are covered by forwarding and the multiplier is free.
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int CNT_W   = 3,
    parameter int MUL_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_RsAddr,
    input  logic [REG_ADDR_W-1:0] id_RtAddr,
    input  logic                  id_Rs_used,
    input  logic                  id_Rt_used,
    input  logic [REG_ADDR_W-1:0] id_RdAddr,
    input  logic                  id_Reg_w,
    input  logic [1:0]            id_class,
    input  logic                  flush,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_RdAddr,
    output logic                  stall,
    output logic                  issue,
    output logic [NREG-1:0]       busy_mask
);

    logic [CNT_W-1:0] cnt_arr [NREG];
    logic [NREG-1:0]  cnt_nz;
    logic [NREG-1:0]  pending;
    logic [NREG-1:1]  set_vec;
    logic [NREG-1:1]  clr_vec;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] mul_cnt_reg;
    logic             haz_rs;
    logic             haz_rt;
    logic             waw;
    logic             mul_struct;
    logic             is_mul;
    logic             id_live;

    // r0 carries no state, so a zero "not ready" bit makes it hazard-free.
    assign cnt_arr[0] = '0;
    assign pending[0] = 1'b0;
    assign cnt_nz[0]  = 1'b0;

    assign issue_cnt = CNT_W'(class_latency(id_class, MUL_LAT));

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_entry
            assign set_vec[gi] = issue && id_Reg_w && (int'(id_RdAddr) == gi);
            assign clr_vec[gi] = wb_valid && (int'(wb_RdAddr) == gi);
            assign cnt_nz[gi]  = (cnt_arr[gi] != '0);

            sb_entry #(
                .CNT_W(CNT_W)
            ) u_entry (
                .clk     (clk),
                .rst     (rst),
                .set     (set_vec[gi]),
                .set_cnt (issue_cnt),
                .clr     (clr_vec[gi]),
                .cnt     (cnt_arr[gi]),
                .pending (pending[gi])
            );
        end
    endgenerate

    assign is_mul     = (id_class == CLS_MUL);
    assign haz_rs     = id_Rs_used && cnt_nz[id_RsAddr];
    assign haz_rt     = id_Rt_used && cnt_nz[id_RtAddr];
    assign waw        = id_Reg_w && cnt_nz[id_RdAddr];
    assign mul_struct = is_mul && (mul_cnt_reg != '0);

    assign id_live   = id_valid && !flush;
    assign stall     = id_live && (haz_rs || haz_rt || waw || mul_struct);
    assign issue     = id_live && !stall;
    assign busy_mask = pending;

    // The multiplier is not pipelined: any issued MUL occupies it, even without Rd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mul_cnt_reg <= '0;
        else if (issue && is_mul)
            mul_cnt_reg <= CNT_W'(MUL_LAT - 1);
        else if (mul_cnt_reg != '0)
            mul_cnt_reg <= mul_cnt_reg - CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed test-plan scenarios plus random traffic against a cycle-stamp
// reference model of register readiness and multiplier occupancy.
module tb_hazard_scoreboard;

    localparam int NREG    = 32;
    localparam int CNT_W   = 3;
    localparam int MUL_LAT = 4;

    localparam logic [1:0] C_ALU  = 2'b00;
    localparam logic [1:0] C_LOAD = 2'b01;
    localparam logic [1:0] C_MUL  = 2'b10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            id_valid = 1'b0;
    logic [4:0]      id_RsAddr = '0;
    logic [4:0]      id_RtAddr = '0;
    logic            id_Rs_used = 1'b0;
    logic            id_Rt_used = 1'b0;
    logic [4:0]      id_RdAddr = '0;
    logic            id_Reg_w = 1'b0;
    logic [1:0]      id_class = '0;
    logic            flush = 1'b0;
    logic            wb_valid = 1'b0;
    logic [4:0]      wb_RdAddr = '0;
    logic            stall;
    logic            issue;
    logic [NREG-1:0] busy_mask;

    hazard_scoreboard #(
        .NREG    (NREG),
        .CNT_W   (CNT_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_RsAddr  (id_RsAddr),
        .id_RtAddr  (id_RtAddr),
        .id_Rs_used (id_Rs_used),
        .id_Rt_used (id_Rt_used),
        .id_RdAddr  (id_RdAddr),
        .id_Reg_w   (id_Reg_w),
        .id_class   (id_class),
        .flush      (flush),
        .wb_valid   (wb_valid),
        .wb_RdAddr  (wb_RdAddr),
        .stall      (stall),
        .issue      (issue),
        .busy_mask  (busy_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: absolute cycle from which each register / the multiplier is usable.
    int ready_at [NREG];
    bit pend     [NREG];
    int mul_free_at;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            ready_at[r] = 0;
            pend[r]     = 1'b0;
        end
        mul_free_at = 0;
    endtask

    task automatic id_set(input bit v, input logic [1:0] c,
                          input logic [4:0] rs, input bit rsu,
                          input logic [4:0] rt, input bit rtu,
                          input logic [4:0] rd, input bit rw);
        id_valid = v; id_class = c;
        id_RsAddr = rs; id_Rs_used = rsu;
        id_RtAddr = rt; id_Rt_used = rtu;
        id_RdAddr = rd; id_Reg_w = rw;
    endtask

    function automatic int lat_of(input logic [1:0] c);
        if (c == C_LOAD) return 1;
        if (c == C_MUL)  return MUL_LAT - 1;
        return 0;
    endfunction

    // One ID cycle: compare against the model, optionally against a test-plan
    // constant (ws/wi < 0 means none), then advance the model and the clock.
    task automatic step(input int ws, input int wi);
        bit hz, e_stall, e_issue;
        logic [31:0] e_mask;
        #1;
        hz = (id_Rs_used && id_RsAddr != 0 && cyc < ready_at[id_RsAddr]) ||
             (id_Rt_used && id_RtAddr != 0 && cyc < ready_at[id_RtAddr]) ||
             (id_Reg_w   && id_RdAddr != 0 && cyc < ready_at[id_RdAddr]) ||
             (id_class == C_MUL && cyc < mul_free_at);
        e_stall = id_valid && !flush && hz;
        e_issue = id_valid && !flush && !hz;
        e_mask = '0;
        for (int r = 1; r < NREG; r++) e_mask[r] = pend[r];
        chk("stall", 32'(stall), 32'(e_stall));
        chk("issue", 32'(issue), 32'(e_issue));
        chk("busy_mask", busy_mask, e_mask);
        if (ws >= 0) chk("plan_stall", 32'(stall), ws);
        if (wi >= 0) chk("plan_issue", 32'(issue), wi);
        $display("cyc=%0d v=%0b cls=%0d rs=%0d/%0b rt=%0d/%0b rd=%0d/%0b fl=%0b wb=%0b/%0d stall=%0b issue=%0b mask=%08h",
                 cyc, id_valid, id_class, id_RsAddr, id_Rs_used, id_RtAddr, id_Rt_used,
                 id_RdAddr, id_Reg_w, flush, wb_valid, wb_RdAddr, stall, issue, busy_mask);
        if (wb_valid && wb_RdAddr != 0) pend[wb_RdAddr] = 1'b0;
        if (e_issue && id_Reg_w && id_RdAddr != 0) begin
            pend[id_RdAddr]     = 1'b1;
            ready_at[id_RdAddr] = cyc + 1 + lat_of(id_class);
        end
        if (e_issue && id_class == C_MUL) mul_free_at = cyc + MUL_LAT;
        @(posedge clk);
        @(negedge clk);
        id_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            id_set(0, C_ALU, 0, 0, 0, 0, 0, 0);
            step(0, 0);
        end
    endtask

    initial begin
        model_clear();
        // Reset state with a live ID instruction.
        id_set(1, C_ALU, 1, 1, 2, 1, 3, 1);
        #1;
        chk("rst_mask", busy_mask, 32'h0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_issue", 32'(issue), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        id_valid = 1'b0;

        // LOAD -> dependent reader: one bubble.
        id_set(1, C_LOAD, 0, 0, 0, 0, 8, 1); step(0, 1);
        id_set(1, C_ALU, 8, 1, 0, 0, 3, 1);  step(1, 0);
        id_set(1, C_ALU, 8, 1, 0, 0, 3, 1);  step(0, 1);

        // MUL -> dependent reader: MUL_LAT-1 bubbles.
        id_set(1, C_MUL, 1, 1, 2, 1, 9, 1); step(0, 1);
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            id_set(1, C_ALU, 0, 0, 9, 1, 4, 1); step(1, 0);
        end
        id_set(1, C_ALU, 0, 0, 9, 1, 4, 1); step(0, 1);

        // Back-to-back independent MULs: structural stall.
        id_set(1, C_MUL, 1, 1, 2, 1, 10, 1); step(0, 1);
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            id_set(1, C_MUL, 1, 1, 0, 0, 11, 1); step(1, 0);
        end
        id_set(1, C_MUL, 1, 1, 0, 0, 11, 1); step(0, 1);
        idle(MUL_LAT);

        // ALU dependency never stalls; r0 never hazards.
        id_set(1, C_ALU, 0, 0, 0, 0, 5, 1);  step(0, 1);
        id_set(1, C_ALU, 5, 1, 5, 1, 6, 1);  step(0, 1);
        id_set(1, C_LOAD, 0, 0, 0, 0, 0, 1); step(0, 1);
        id_set(1, C_LOAD, 0, 1, 0, 1, 0, 1); step(0, 1);
        chk("r0_mask", 32'(busy_mask[0]), 32'd0);

        // Issue set beats same-cycle writeback clear.
        id_set(1, C_LOAD, 0, 0, 0, 0, 7, 1);
        wb_valid = 1'b1; wb_RdAddr = 5'd7;
        step(0, 1);
        chk("r7_set", 32'(busy_mask[7]), 32'd1);
        idle(1);
        wb_valid = 1'b1; wb_RdAddr = 5'd7;
        idle(1);
        chk("r7_clr", 32'(busy_mask[7]), 32'd0);

        // Flushed MUL leaves no trace.
        id_set(1, C_MUL, 1, 1, 2, 1, 12, 1); flush = 1'b1; step(0, 0);
        id_set(1, C_MUL, 1, 1, 2, 1, 12, 1); step(0, 1);
        idle(MUL_LAT);

        // Asynchronous reset mid-operation with cnt[9]=2, mul_cnt=2.
        id_set(1, C_MUL, 1, 1, 2, 1, 9, 1); step(0, 1);
        idle(1);
        id_set(1, C_ALU, 0, 0, 9, 1, 4, 1);
        #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_mask", busy_mask, 32'h0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_issue", 32'(issue), 32'd1);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        id_set(1, C_ALU, 0, 0, 9, 1, 4, 1); step(0, 1);
        id_set(1, C_MUL, 1, 1, 2, 1, 13, 1); step(0, 1);

        // Random traffic on a small register window to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            id_set($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            flush     = ($urandom_range(0, 9) == 0);
            wb_valid  = 1'($urandom_range(0, 1));
            wb_RdAddr = 5'($urandom_range(0, 7));
            step(-1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Issue-side scoreboard for the 5-stage pipeline; the producer-side counterpart of the EX-stage forwarding logic. For every architectural register it tracks outstanding writes and the cycles left until the result becomes forwardable. It stalls the ID-stage instruction when a source or destination is not yet covered by the EX/MEM or MEM/WB forwarding paths, or when the non-pipelined multiplier is busy. It sits between decode and the ID/EX register and drives the PC/IF-ID write-enable and the ID/EX bubble insert.

## Interface
Parameters:
- NREG, 32, architectural register count
- CNT_W, 3, countdown width (must hold MUL_LAT-1)
- MUL_LAT, 4, multiplier result latency in cycles (≥2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_RsAddr  in  5  source A register
- id_RtAddr  in  5  source B register
- id_Rs_used  in  1  instruction reads Rs
- id_Rt_used  in  1  instruction reads Rt
- id_RdAddr  in  5  destination register
- id_Reg_w  in  1  instruction writes Rd
- id_class  in  2  result class: 00 ALU, 01 LOAD, 10 MUL, 11 reserved (treated as ALU)
- flush  in  1  squash the ID instruction this cycle
- wb_valid  in  1  writeback commits this cycle
- wb_RdAddr  in  5  writeback destination
- stall  out  1  hold PC/IF-ID, insert bubble into ID/EX
- issue  out  1  ID instruction advances this cycle
- busy_mask  out  NREG  pending[r]; bit 0 always 0

## Operation
- State per register r (1..NREG-1): cnt[r] (CNT_W bits), pending[r] (1 bit). Register 0 has no state; its reads and writes never hazard.
- Global: mul_cnt (CNT_W bits), nonzero while the multiplier is busy.
- Hazards, combinational from current state:
  - haz_rs = id_Rs_used && Rs≠0 && cnt[Rs]≠0; haz_rt likewise.
  - waw = id_Reg_w && Rd≠0 && cnt[Rd]≠0.
  - mul_struct = id_class==MUL && mul_cnt≠0.
- stall = id_valid && !flush && (haz_rs | haz_rt | waw | mul_struct).
- issue = id_valid && !flush && !stall.
- On issue with id_Reg_w and Rd≠0: pending[Rd]←1; cnt[Rd]← ALU:0, LOAD:1, MUL:MUL_LAT-1.
- On issue with class MUL (regardless of Reg_w): mul_cnt←MUL_LAT-1.
- Every cycle, each nonzero cnt and mul_cnt decrements by 1, saturating at 0.
- wb_valid with wb_RdAddr≠0 clears pending[wb_RdAddr].
- Simultaneous events on the same register:
  - issue set vs. decrement: set wins.
  - issue set vs. writeback clear: set wins, so pending stays 1.
- flush suppresses issue and all state updates from the ID instruction. In-flight counters continue unaffected.

## Timing
- Reset: all cnt, pending and mul_cnt = 0. stall=0, issue=id_valid&&!flush, busy_mask=0.
- Reset asserted mid-operation clears all state immediately; no hazards are remembered afterwards.
- stall and issue are combinational, same cycle as the ID inputs. State updates on the rising clk edge.
- Dependent-instruction stall bubbles after the producer issues:
  - ALU: 0
  - LOAD: 1
  - MUL: MUL_LAT-1
- Back-to-back MULs are separated by MUL_LAT-1 stall cycles.
- busy_mask reflects registered state, so it lags one cycle after issue/writeback.

## Structure
- Shared pipeline_pkg holds:
  - result-class constants CLS_ALU=2'b00, CLS_LOAD=2'b01, CLS_MUL=2'b10
  - REG_ADDR_W=5
  - forwarding select encodings, shared with the forwarding unit
- One sub-module, sb_entry: a single register's cnt/pending with set, clear and decrement ports. It is instantiated NREG-1 times via generate. mul_cnt and the hazard muxing live in the top module.

## Test plan
- LOAD rd=8 issued at cycle 0; ID at cycle 1 reads Rs=8 → stall=1 at cycle 1, stall=0 and issue=1 at cycle 2.
- MUL rd=9 (MUL_LAT=4) at cycle 0; dependent reads Rt=9 → stall=1 at cycles 1–3, issue=1 at cycle 4. A second MUL with no data dependence is also held until cycle 4.
- ALU rd=5 followed by a reader of r5 → stall=0 throughout. An instruction reading/writing r0 after LOAD rd=0 → no stall, busy_mask[0]=0.
- Same-cycle issue of LOAD rd=7 and wb_valid with wb_RdAddr=7 → busy_mask[7]=1 next cycle. A later wb of r7 alone → busy_mask[7]=0.
- flush=1 with a MUL in ID → issue=0, stall=0. The next MUL issues with no structural stall.
- rst asserted while cnt[9]=2 and mul_cnt=2 → all state 0 immediately. A reader of r9 issues at once after reset release.
